spi_regfile_slave: RTL and testbench
====================================

SPI_REGFILE_SLAVE -- requirements
Module: spi_regfile_slave

Interface
REQ-001 Parameter DATA_W, default 8: register and data-phase width in bits, range 8..32.
REQ-002 Parameter ADDR_W, default 8: address-phase width in bits, range 4..16.
REQ-003 Parameter DEPTH, default 16: number of registers, at most 2**ADDR_W.
REQ-004 Parameter CPOL, default 0: sck idle level.
REQ-005 Parameter CPHA, default 0: 0 = sample on leading edge; 1 = sample on trailing edge.
REQ-006 clk  input  1  single system clock; all logic is clocked on the rising edge of clk.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 cs  input  1  chip select, active low, asynchronous to clk.
REQ-009 sck  input  1  serial clock, asynchronous to clk; clk frequency is at least 4x sck.
REQ-010 mosi  input  1  master-out serial data, MSB first.
REQ-011 miso  output  1  master-in serial data, MSB first.
REQ-012 miso_oe  output  1  miso drive enable.
REQ-013 wr_valid  output  1  one-clk pulse on a completed write frame.
REQ-014 wr_addr  output  ADDR_W  address of the last completed write.
REQ-015 wr_data  output  DATA_W  data of the last completed write.
REQ-016 frame_err  output  1  one-clk pulse on an aborted frame.

Function
REQ-017 cs, sck and mosi SHALL each pass through a 2-flop synchroniser; all sck edge detection is done on the synchronised sck in the clk domain.
REQ-018 Sample edge SHALL be the rising sck edge when CPOL equals CPHA, otherwise the falling edge; the other edge is the shift edge.
REQ-019 Frame format SHALL be 8-bit command, then ADDR_W-bit address, then DATA_W-bit data; total 8+ADDR_W+DATA_W sample edges.
REQ-020 Command 8'h01 = write; command 8'hFF = read; any other command SHALL complete the frame with no register access and miso held 0.
REQ-021 States SHALL be IDLE, CMD, ADDR, DATA, DONE.
REQ-022 IDLE->CMD on synchronised cs falling; CMD->ADDR after 8 samples; ADDR->DATA after ADDR_W samples; DATA->DONE after DATA_W samples; DONE->IDLE on synchronised cs high.
REQ-023 A synchronised cs rise in CMD, ADDR or DATA SHALL return to IDLE, pulse frame_err for one clk, and discard the frame with no register write and no wr_valid.
REQ-024 A write SHALL update register[addr] and pulse wr_valid, with wr_addr/wr_data updated, on the clk after the final data sample edge is detected.
REQ-025 A write to addr >= DEPTH SHALL pulse wr_valid and update wr_addr/wr_data, but SHALL leave the register array unchanged.
REQ-026 A read SHALL load register[addr] into the output shifter on the clk after the final address sample edge; a read of addr >= DEPTH SHALL load 0.
REQ-027 When CPHA=0, miso SHALL present the data MSB from the load clk onward and shift on each subsequent shift edge.
REQ-028 When CPHA=1, miso SHALL present each data bit from the shift edge that precedes its sample edge.
REQ-029 miso SHALL be 0 outside the DATA state of a read frame.
REQ-030 miso_oe SHALL equal the inverse of synchronised cs.
REQ-031 Sample and shift edges detected in IDLE or DONE SHALL be ignored.
REQ-032 Bit counters SHALL clear on every entry to CMD.

Reset
REQ-033 rst SHALL asynchronously force:
- state = IDLE and all counters = 0
- all registers = 0 and synchroniser flops to the idle levels (cs = 1, sck = CPOL)
- miso = 0, miso_oe = 0, wr_valid = 0, frame_err = 0, wr_addr = 0, wr_data = 0
REQ-034 rst asserted mid-frame SHALL abort the frame with no frame_err pulse; after release the block SHALL wait for a fresh cs falling edge.

Verification
REQ-035 Mode 0, defaults: write 01/03/A5 -> wr_valid pulses once with wr_addr=03, wr_data=A5; a following read FF/03/xx returns A5 on miso.
REQ-036 All four CPOL/CPHA modes: write 01/07/3C, then read FF/07 -> miso shows 0011_1100 MSB-first, sampled correctly in each mode.
REQ-037 Write 01/20/55 with DEPTH=16 -> wr_valid pulses; a read of 0x20 returns 00; registers 0..15 are unchanged.
REQ-038 cs raised after 12 bits of a write -> frame_err pulses once, no wr_valid, target register unchanged, and the next full frame works.
REQ-039 Command 8'h42 frame -> no wr_valid, miso=0 throughout, and a cs high/low cycle returns the block to CMD.
REQ-040 DATA_W=16, ADDR_W=4: write 01/5/BEEF, then read -> 16-bit BEEF returned; rst asserted mid-read -> miso=0 immediately.

Source files
------------

// File: rtl/spi_regfile_slave.sv
// SPI slave in front of a small register file: synchronised pins, a command/address/data
// frame, write pulses with address/data, and MSB-first read-back on miso.
module spi_regfile_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err
);

  // state | meaning
  // IDLE  | waiting for a cs falling edge
  // CMD   | shifting in the 8-bit command
  // ADDR  | shifting in the address
  // DATA  | shifting data in (write) or out (read)
  // DONE  | frame complete, waiting for cs high
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  localparam int          MAX_AD    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int          SR_W      = (MAX_AD > 8) ? MAX_AD : 8;
  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0]  CMD_LAST  = 6'd7;
  localparam logic [5:0]  ADDR_LAST = 6'(ADDR_W - 1);
  localparam logic [5:0]  DATA_LAST = 6'(DATA_W - 1);
  localparam logic [7:0]  CMD_WR    = 8'h01;
  localparam logic [7:0]  CMD_RD    = 8'hFF;
  localparam logic        SCK_IDLE  = 1'(CPOL);
  localparam bit          SAMPLE_RISE = (CPOL == CPHA);

  state_t              state, state_nxt;
  logic                cs_s1, cs_s2, cs_d;
  logic                sck_s1, sck_s2, sck_d;
  logic                mosi_s1, mosi_s2;
  logic                started, armed;
  logic [5:0]          cnt, last_cnt;
  logic [SR_W-2:0]     sr;
  logic [SR_W-1:0]     sr_in;
  logic [7:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   tx_sr, rd_data;
  logic [ADDR_W-1:0]   rd_addr;
  logic                miso_q;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic sck_rise, sck_fall, sample_edge, shift_edge, cs_fall, cs_rise;
  logic in_frame, abort, take, phase_end, enter_cmd;
  logic wr_fire, wr_in_range, rd_load, rd_in_range, tx_shift;

  // A cs held low through reset must not look like a new frame, so edges
  // only count once cs has been seen high after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sck_s1  <= SCK_IDLE;
      sck_s2  <= SCK_IDLE;
      sck_d   <= SCK_IDLE;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      started <= 1'b0;
      armed   <= 1'b0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      started <= 1'b1;
      if (started && cs_s1) armed <= 1'b1;
    end
  end

  assign sck_rise    = sck_s2 & ~sck_d;
  assign sck_fall    = ~sck_s2 & sck_d;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign cs_fall     = cs_d & ~cs_s2 & armed;
  assign cs_rise     = ~cs_d & cs_s2;
  assign miso_oe     = ~cs_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cs_fall) state_nxt = S_CMD;
      S_CMD:  if (cs_rise) state_nxt = S_IDLE;
              else if (sample_edge && cnt == CMD_LAST) state_nxt = S_ADDR;
      S_ADDR: if (cs_rise) state_nxt = S_IDLE;
              else if (sample_edge && cnt == ADDR_LAST) state_nxt = S_DATA;
      S_DATA: if (cs_rise) state_nxt = S_IDLE;
              else if (sample_edge && cnt == DATA_LAST) state_nxt = S_DONE;
      S_DONE: if (cs_s2) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    last_cnt = DATA_LAST;
    miso     = 1'b0;
    case (state)
      S_CMD:   last_cnt = CMD_LAST;
      S_ADDR:  last_cnt = ADDR_LAST;
      default: last_cnt = DATA_LAST;
    endcase
    if (state == S_DATA && cmd_q == CMD_RD) miso = miso_q;
  end

  assign in_frame    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
  assign abort       = in_frame && cs_rise;
  assign take        = in_frame && sample_edge && !cs_rise;
  assign phase_end   = take && (cnt == last_cnt);
  assign enter_cmd   = (state == S_IDLE) && cs_fall;
  assign sr_in       = {sr, mosi_s2};

  assign wr_fire     = phase_end && (state == S_DATA) && (cmd_q == CMD_WR);
  assign wr_in_range = int'(addr_q) < DEPTH;
  assign rd_addr     = sr_in[ADDR_W-1:0];
  assign rd_in_range = int'(rd_addr) < DEPTH;
  assign rd_data     = rd_in_range ? regs[rd_addr[IDX_W-1:0]] : '0;
  assign rd_load     = phase_end && (state == S_ADDR) && (sr_in[7:0] == sr_in[7:0]) && (cmd_q == CMD_RD);
  // CPHA=0 already presents the MSB at load, so the first shift edge waits for a data sample.
  assign tx_shift    = (state == S_DATA) && shift_edge && !cs_rise && ((CPHA != 0) || (cnt != 6'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sr        <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      tx_sr     <= '0;
      miso_q    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_valid  <= wr_fire;
      frame_err <= abort;
      if (enter_cmd) begin
        cnt <= '0;
      end else if (take) begin
        sr  <= sr_in[SR_W-2:0];
        cnt <= phase_end ? 6'd0 : cnt + 6'd1;
      end
      if (phase_end && state == S_CMD)  cmd_q  <= sr_in[7:0];
      if (phase_end && state == S_ADDR) addr_q <= sr_in[ADDR_W-1:0];
      if (wr_fire) begin
        wr_addr <= addr_q;
        wr_data <= sr_in[DATA_W-1:0];
      end
      if (rd_load) begin
        if (CPHA == 0) begin
          miso_q <= rd_data[DATA_W-1];
          tx_sr  <= {rd_data[DATA_W-2:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
          tx_sr  <= rd_data;
        end
      end else if (tx_shift) begin
        miso_q <= tx_sr[DATA_W-1];
        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Out-of-range writes still report on wr_valid but leave the array alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_fire && wr_in_range) begin
      regs[addr_q[IDX_W-1:0]] <= sr_in[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Bench: four SPI modes on the default geometry plus a 16-bit data / 4-bit address
// instance, driven by a bit-banged master and compared against a register-array model.
`timescale 1ns/1ps
module tb_spi_regfile_slave;
  localparam int NI = 5;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cs_a   [NI];
  logic        sck_a  [NI];
  logic        mosi_a [NI];
  logic        miso_a [NI];
  logic        oe_a   [NI];
  logic        wrv_a  [NI];
  logic        ferr_a [NI];
  logic [7:0]  wa8    [4];
  logic [7:0]  wd8    [4];
  logic [3:0]  wa16;
  logic [15:0] wd16;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_regfile_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk(clk), .rst(rst), .cs(cs_a[g]), .sck(sck_a[g]), .mosi(mosi_a[g]),
      .miso(miso_a[g]), .miso_oe(oe_a[g]), .wr_valid(wrv_a[g]),
      .wr_addr(wa8[g]), .wr_data(wd8[g]), .frame_err(ferr_a[g]));
  end

  spi_regfile_slave #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .CPOL(0), .CPHA(0)) u_wide (
    .clk(clk), .rst(rst), .cs(cs_a[4]), .sck(sck_a[4]), .mosi(mosi_a[4]),
    .miso(miso_a[4]), .miso_oe(oe_a[4]), .wr_valid(wrv_a[4]),
    .wr_addr(wa16), .wr_data(wd16), .frame_err(ferr_a[4]));

  logic [15:0] mdl [NI][16];
  int wrv_cnt [NI];
  int ferr_cnt [NI];
  int n_checks = 0;
  int n_fail   = 0;

  initial for (int i = 0; i < NI; i++) begin wrv_cnt[i] = 0; ferr_cnt[i] = 0; end

  always @(negedge clk)
    for (int i = 0; i < NI; i++) begin
      if (wrv_a[i]  === 1'b1) wrv_cnt[i]++;
      if (ferr_a[i] === 1'b1) ferr_cnt[i]++;
    end

  function automatic bit cpol_of(int m);  return (m < 4) ? bit'(m / 2) : 1'b0; endfunction
  function automatic bit cpha_of(int m);  return (m < 4) ? bit'(m % 2) : 1'b0; endfunction
  function automatic int aw_of(int m);    return (m == 4) ? 4 : 8; endfunction
  function automatic int dw_of(int m);    return (m == 4) ? 16 : 8; endfunction
  function automatic logic [15:0] wr_addr_of(int m);
    return (m == 4) ? 16'(wa16) : 16'(wa8[m]);
  endfunction
  function automatic logic [15:0] wr_data_of(int m);
    return (m == 4) ? wd16 : 16'(wd8[m]);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NI; i++) for (int j = 0; j < 16; j++) mdl[i][j] = 16'h0;
  endtask

  task automatic xfer(input int m, input int nbits, input logic [63:0] tx,
                      input bit keep_cs, output logic [63:0] rx);
    logic pol, pha;
    pol = cpol_of(m);
    pha = cpha_of(m);
    rx = '0;
    cs_a[m] = 1'b0;
    clks(H);
    check($sformatf("m%0d_miso_oe_active", m), 64'(oe_a[m]), 64'd1);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!pha) begin
        mosi_a[m] = tx[i];
        clks(H);
        rx = {rx[62:0], miso_a[m]};
        sck_a[m] = ~pol;
        clks(H);
        sck_a[m] = pol;
      end else begin
        sck_a[m]  = ~pol;
        mosi_a[m] = tx[i];
        clks(H);
        rx = {rx[62:0], miso_a[m]};
        sck_a[m] = pol;
        clks(H);
      end
    end
    if (!keep_cs) begin
      clks(H);
      cs_a[m] = 1'b1;
      clks(2 * H);
    end
  endtask

  task automatic do_frame(input int m, input logic [7:0] cmd, input int addr, input logic [15:0] data);
    int a_w, d_w, wv0, fe0;
    logic [15:0] dmask, dval;
    logic [63:0] tx, rx, exp_rx;
    a_w   = aw_of(m);
    d_w   = dw_of(m);
    dmask = (d_w == 16) ? 16'hFFFF : 16'h00FF;
    dval  = data & dmask;
    tx    = (64'(cmd) << (a_w + d_w)) | (64'(addr) << d_w) | 64'(dval);
    wv0   = wrv_cnt[m];
    fe0   = ferr_cnt[m];
    xfer(m, 8 + a_w + d_w, tx, 1'b0, rx);
    exp_rx = 64'd0;
    if (cmd == 8'hFF && addr < 16) exp_rx = 64'(mdl[m][addr]);
    check($sformatf("m%0d_miso_c%02h_a%0h", m, cmd, addr), rx, exp_rx);
    check($sformatf("m%0d_wr_valid_count", m), 64'(wrv_cnt[m] - wv0), (cmd == 8'h01) ? 64'd1 : 64'd0);
    check($sformatf("m%0d_no_frame_err", m), 64'(ferr_cnt[m] - fe0), 64'd0);
    if (cmd == 8'h01) begin
      check($sformatf("m%0d_wr_addr", m), 64'(wr_addr_of(m)), 64'(addr));
      check($sformatf("m%0d_wr_data", m), 64'(wr_data_of(m)), 64'(dval));
      if (addr < 16) mdl[m][addr] = dval;
    end
  endtask

  task automatic check_reset_outputs(input string when_tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_m%0d_miso", when_tag, i),      64'(miso_a[i]), 64'd0);
      check($sformatf("%s_m%0d_oe", when_tag, i),        64'(oe_a[i]),   64'd0);
      check($sformatf("%s_m%0d_wrv", when_tag, i),       64'(wrv_a[i]),  64'd0);
      check($sformatf("%s_m%0d_ferr", when_tag, i),      64'(ferr_a[i]), 64'd0);
      check($sformatf("%s_m%0d_wr_addr", when_tag, i),   64'(wr_addr_of(i)), 64'd0);
      check($sformatf("%s_m%0d_wr_data", when_tag, i),   64'(wr_data_of(i)), 64'd0);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, r, addr, fe0, wv0;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [63:0] rx;

    for (int i = 0; i < NI; i++) begin
      cs_a[i]   = 1'b1;
      sck_a[i]  = cpol_of(i);
      mosi_a[i] = 1'b0;
    end
    clear_model();
    rst = 1'b1;
    clks(5);
    check_reset_outputs("in_reset");
    rst = 1'b0;
    clks(5);
    check_reset_outputs("after_reset");

    // basic write then read-back on mode 0
    do_frame(0, 8'h01, 3, 16'h00A5);
    do_frame(0, 8'hFF, 3, 16'h0000);

    // every mode: write 3C to 7 and read it back
    for (int i = 0; i < 4; i++) begin
      do_frame(i, 8'h01, 7, 16'h003C);
      do_frame(i, 8'hFF, 7, 16'h0000);
    end

    // out-of-range write reports but does not land anywhere
    do_frame(0, 8'h01, 8'h20, 16'h0055);
    do_frame(0, 8'hFF, 8'h20, 16'h0000);
    for (int a = 0; a < 16; a++) do_frame(0, 8'hFF, a, 16'h0000);

    // cs raised after 12 bits of a write
    do_frame(1, 8'h01, 9, 16'h0011);
    fe0 = ferr_cnt[1];
    wv0 = wrv_cnt[1];
    xfer(1, 12, ((64'h01 << 16) | (64'h09 << 8) | 64'h77) >> 12, 1'b0, rx);
    check("abort_frame_err_count", 64'(ferr_cnt[1] - fe0), 64'd1);
    check("abort_no_wr_valid", 64'(wrv_cnt[1] - wv0), 64'd0);
    do_frame(1, 8'hFF, 9, 16'h0000);
    do_frame(1, 8'h01, 9, 16'h00C3);
    do_frame(1, 8'hFF, 9, 16'h0000);

    // unknown command does nothing; the following frame still decodes
    do_frame(0, 8'h42, 3, 16'h00FF);
    do_frame(0, 8'hFF, 3, 16'h0000);

    // wide instance
    do_frame(4, 8'h01, 5, 16'hBEEF);
    do_frame(4, 8'hFF, 5, 16'h0000);

    for (int it = 0; it < 30; it++) begin
      m = int'($urandom_range(0, NI - 1));
      r = int'($urandom_range(0, 9));
      if (r < 4)      cmd = 8'h01;
      else if (r < 8) cmd = 8'hFF;
      else            cmd = 8'($urandom_range(2, 254));
      addr = (m == 4) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 31));
      data = 16'($urandom);
      do_frame(m, cmd, addr, data);
    end

    // reset in the middle of a read on the wide instance
    do_frame(4, 8'h01, 5, 16'hBEEF);
    fe0 = ferr_cnt[4];
    xfer(4, 16, ((64'hFF << 20) | (64'h5 << 16)) >> 12, 1'b1, rx);
    check("midread_first_nibble", rx, 64'hB);
    clks(6);
    check("midread_miso_driving", 64'(miso_a[4]), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_miso_immediate", 64'(miso_a[4]), 64'd0);
    check("rst_oe_immediate", 64'(oe_a[4]), 64'd0);
    clear_model();
    clks(4);
    rst = 1'b0;
    clks(20);
    cs_a[4] = 1'b1;
    clks(20);
    check("rst_no_frame_err", 64'(ferr_cnt[4] - fe0), 64'd0);
    do_frame(4, 8'hFF, 5, 16'h0000);
    do_frame(4, 8'h01, 5, 16'h1234);
    do_frame(4, 8'hFF, 5, 16'h0000);
    do_frame(0, 8'hFF, 3, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
